// File: rtl/write_reg_dst_pipe_pkg.sv
// Shared MIPS register-file constants: destination source indices and the link register.
package write_reg_dst_pipe_pkg;

  localparam int SRC_RT   = 0;
  localparam int SRC_RD   = 1;
  localparam int SRC_LINK = 2;

  localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/dst_stage_reg.sv
// One pipeline stage holding a destination register address and its valid bit.
module dst_stage_reg #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              next_valid,
  input  logic [ADDR_W-1:0] next_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value and the chain shifts by exactly one place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!stall) begin
      valid <= next_valid;
      addr  <= next_addr;
    end
  end

endmodule

// File: rtl/write_reg_dst_pipe.sv
// Destination-register select plus a DEPTH-stage tracker of in-flight writes,
// exposing writeback, per-stage hazard hits and an in-flight count.
module write_reg_dst_pipe
  import write_reg_dst_pipe_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_bus,
  input  logic [$clog2(NUM_SRC)-1:0] sel,
  input  logic                       in_valid,
  input  logic                       reg_write,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          rs_q,
  input  logic [ADDR_W-1:0]          rt_q,
  output logic [ADDR_W-1:0]          write_reg,
  output logic                       wb_valid,
  output logic [ADDR_W-1:0]          wb_reg,
  output logic [DEPTH-1:0]           hit_rs,
  output logic [DEPTH-1:0]           hit_rt,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic              entry_valid;
  logic              accept;
  logic              retire;
  logic [DEPTH-1:0]  stage_valid;
  logic [ADDR_W-1:0] stage_addr [DEPTH];
  logic [CNT_W-1:0]  inflight_next;

  // NOTE: combinational outputs get a default before any conditional override,
  // so no path leaves them unassigned and no latch is inferred.
  always_comb begin
    write_reg = src_bus[SRC_RT*ADDR_W +: ADDR_W];
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(sel) == k) write_reg = src_bus[k*ADDR_W +: ADDR_W];
    end
  end

  // Register 0 is hardwired, so writes to it never create a hazard.
  assign entry_valid = in_valid & reg_write & (write_reg != '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      dst_stage_reg #(.ADDR_W(ADDR_W)) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .next_valid (entry_valid),
        .next_addr  (write_reg),
        .valid      (stage_valid[i]),
        .addr       (stage_addr[i])
      );
    end else begin : g_tail
      dst_stage_reg #(.ADDR_W(ADDR_W)) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .next_valid (stage_valid[i-1]),
        .next_addr  (stage_addr[i-1]),
        .valid      (stage_valid[i]),
        .addr       (stage_addr[i])
      );
    end
  end

  assign wb_valid = stage_valid[DEPTH-1];
  assign wb_reg   = stage_addr[DEPTH-1];

  always_comb begin
    hit_rs = '0;
    hit_rt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_rs[i] = stage_valid[i] && (stage_addr[i] == rs_q) && (rs_q != '0);
      hit_rt[i] = stage_valid[i] && (stage_addr[i] == rt_q) && (rt_q != '0);
    end
  end

  assign accept = !stall && !flush && entry_valid;
  assign retire = !stall && !flush && stage_valid[DEPTH-1];

  // Entry and retirement on the same edge cancel; the guards stop any wrap.
  always_comb begin
    inflight_next = inflight;
    if (accept && !retire && inflight != CNT_W'(DEPTH)) begin
      inflight_next = inflight + CNT_W'(1);
    end else if (retire && !accept && inflight != '0) begin
      inflight_next = inflight - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else begin
      inflight <= inflight_next;
    end
  end

endmodule

// File: tb/tb_write_reg_dst_pipe.sv
// Directed self-checking bench for write_reg_dst_pipe with default parameters.
module tb_write_reg_dst_pipe;
  import write_reg_dst_pipe_pkg::*;

  localparam int ADDR_W  = 5;
  localparam int NUM_SRC = 3;
  localparam int DEPTH   = 3;

  logic                       clk;
  logic                       rst_n;
  logic [NUM_SRC*ADDR_W-1:0]  src_bus;
  logic [$clog2(NUM_SRC)-1:0] sel;
  logic                       in_valid;
  logic                       reg_write;
  logic                       stall;
  logic                       flush;
  logic [ADDR_W-1:0]          rs_q;
  logic [ADDR_W-1:0]          rt_q;
  logic [ADDR_W-1:0]          write_reg;
  logic                       wb_valid;
  logic [ADDR_W-1:0]          wb_reg;
  logic [DEPTH-1:0]           hit_rs;
  logic [DEPTH-1:0]           hit_rt;
  logic [$clog2(DEPTH+1)-1:0] inflight;

  int checks = 0;
  int errors = 0;

  write_reg_dst_pipe #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_bus   (src_bus),
    .sel       (sel),
    .in_valid  (in_valid),
    .reg_write (reg_write),
    .stall     (stall),
    .flush     (flush),
    .rs_q      (rs_q),
    .rt_q      (rt_q),
    .write_reg (write_reg),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .hit_rs    (hit_rs),
    .hit_rt    (hit_rt),
    .inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] link);
    src_bus = {link, rd, rt};
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [4:0] r, input logic [1:0] n);
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'(v));
    if (v) check({tag, "_wb_reg"}, 32'(wb_reg), 32'(r));
    check({tag, "_inflight"}, 32'(inflight), 32'(n));
  endtask

  initial begin
    rst_n = 1'b0; sel = '0; in_valid = 1'b0; reg_write = 1'b0;
    stall = 1'b0; flush = 1'b0; rs_q = '0; rt_q = '0;
    set_src(5'd4, 5'd9, LINK_REG);
    #2;
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_reg",   32'(wb_reg),   0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_hit_rs",   32'(hit_rs),   0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single rd write travels DEPTH edges to writeback, valid for one cycle.
    sel = 2'd1; in_valid = 1'b1; reg_write = 1'b1;
    #1;
    check("sel_rd_write_reg", 32'(write_reg), 9);
    sel = 2'd2; #1;
    check("sel_link_write_reg", 32'(write_reg), 31);
    sel = 2'd1; #1;
    tick();
    in_valid = 1'b0;
    check_wb("lat_e1", 1'b0, 5'd0, 2'd1);
    tick(); check_wb("lat_e2", 1'b0, 5'd0, 2'd1);
    tick(); check_wb("lat_e3", 1'b1, 5'd9, 2'd1);
    tick(); check_wb("lat_e4", 1'b0, 5'd0, 2'd0);

    // Writes to register 0 are never tracked.
    sel = 2'd0; set_src(5'd0, 5'd9, LINK_REG); in_valid = 1'b1; reg_write = 1'b1;
    #1;
    check("r0_write_reg", 32'(write_reg), 0);
    tick();
    in_valid = 1'b0; rs_q = 5'd0;
    #1;
    check("r0_inflight", 32'(inflight), 0);
    check("r0_hit_rs",   32'(hit_rs),   0);
    // reg_write low with a nonzero destination also creates no entry.
    set_src(5'd6, 5'd9, LINK_REG); in_valid = 1'b1; reg_write = 1'b0;
    tick();
    in_valid = 1'b0; reg_write = 1'b1;
    check("nowrite_inflight", 32'(inflight), 0);

    // Two back-to-back entries and per-stage hazard bitmaps.
    sel = 2'd1; set_src(5'd0, 5'd7, LINK_REG); in_valid = 1'b1;
    tick();
    set_src(5'd0, 5'd12, LINK_REG);
    tick();
    in_valid = 1'b0; rs_q = 5'd7; rt_q = 5'd12;
    #1;
    check("hz_hit_rs",   32'(hit_rs),   32'b010);
    check("hz_hit_rt",   32'(hit_rt),   32'b001);
    check("hz_inflight", 32'(inflight), 2);
    tick(); check_wb("hz_e3", 1'b1, 5'd7,  2'd2);
    check("hz_hit_rs_s2", 32'(hit_rs), 32'b100);
    tick(); check_wb("hz_e4", 1'b1, 5'd12, 2'd1);
    tick(); check_wb("hz_e5", 1'b0, 5'd0,  2'd0);

    // Fill three stages, stall four edges with a pending input, then resume.
    in_valid = 1'b1;
    set_src(5'd0, 5'd3, LINK_REG); tick();
    set_src(5'd0, 5'd5, LINK_REG); tick();
    set_src(5'd0, 5'd6, LINK_REG); tick();
    rs_q = 5'd5; rt_q = 5'd6;
    set_src(5'd0, 5'd8, LINK_REG);
    stall = 1'b1;
    #1;
    check_wb("st_full", 1'b1, 5'd3, 2'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_wb($sformatf("st_hold%0d", i), 1'b1, 5'd3, 2'd3);
      check($sformatf("st_hit_rs%0d", i), 32'(hit_rs), 32'b010);
      check($sformatf("st_hit_rt%0d", i), 32'(hit_rt), 32'b001);
    end
    stall = 1'b0;
    tick();
    in_valid = 1'b0;
    check_wb("st_r1", 1'b1, 5'd5, 2'd3);
    tick(); check_wb("st_r2", 1'b1, 5'd6, 2'd2);
    tick(); check_wb("st_r3", 1'b1, 5'd8, 2'd1);
    tick(); check_wb("st_r4", 1'b0, 5'd0, 2'd0);

    // Flush with stall and in_valid high empties everything.
    in_valid = 1'b1;
    set_src(5'd0, 5'd1, LINK_REG); tick();
    set_src(5'd0, 5'd2, LINK_REG); tick();
    set_src(5'd0, 5'd3, LINK_REG); tick();
    rs_q = 5'd2; rt_q = 5'd3;
    #1;
    check("fl_pre_inflight", 32'(inflight), 3);
    check("fl_pre_hit_rs",   32'(hit_rs),   32'b010);
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    check("fl_inflight", 32'(inflight), 0);
    check("fl_wb_valid", 32'(wb_valid), 0);
    check("fl_hit_rs",   32'(hit_rs),   0);
    check("fl_hit_rt",   32'(hit_rt),   0);

    // Asynchronous reset between edges, then out-of-range sel picks rt.
    in_valid = 1'b1;
    set_src(5'd0, 5'd10, LINK_REG); tick();
    set_src(5'd0, 5'd11, LINK_REG); tick();
    in_valid = 1'b0; rs_q = 5'd10; rt_q = 5'd11;
    #1;
    check("ar_pre_inflight", 32'(inflight), 2);
    check("ar_pre_hit_rs",   32'(hit_rs),   32'b010);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_inflight", 32'(inflight), 0);
    check("ar_hit_rs",   32'(hit_rs),   0);
    check("ar_hit_rt",   32'(hit_rt),   0);
    check("ar_wb_valid", 32'(wb_valid), 0);
    check("ar_wb_reg",   32'(wb_reg),   0);
    rst_n = 1'b1;
    sel = 2'd3; set_src(5'd4, 5'd13, LINK_REG); rt_q = 5'd4;
    #1;
    check("oor_write_reg", 32'(write_reg), 4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ar_post_inflight", 32'(inflight), 1);
    check("ar_post_hit_rt",   32'(hit_rt),   32'b001);
    check("ar_post_hit_rs",   32'(hit_rs),   0);
    tick(); check_wb("ar_e2", 1'b0, 5'd0, 2'd1);
    tick(); check_wb("ar_e3", 1'b1, 5'd4, 2'd1);
    tick(); check_wb("ar_e4", 1'b0, 5'd0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
